encap_stats_counter: RTL and testbench
======================================

# encap_stats_counter

Passive AXI-Stream monitor on the IP encapsulator egress stream. It produces the 64-bit packet and byte totals and the interrupt request that feed `axi_lite_regs` (`pkt_count_in`, `byte_count_in`, `irq_req_in`). It consumes that block's `enable_out` and `clear_counters_out`. Interrupts are coalesced by packet threshold and, optionally, by timeout.

## Interface
- `DATA_WIDTH`, 64: width of the tapped tdata; it sets the tkeep width as `KEEP_W = DATA_WIDTH/8`.
- `IRQ_PKT_THRESH`, 16: number of counted packets per IRQ. A value of 0 disables the threshold trigger.
- `IRQ_TIMEOUT`, 1024: idle cycles after the first pending packet before an IRQ fires (used only with the macro).
- `clk` in 1: the single clock.
- `rstn` in 1: synchronous, active-low reset.
- `mon_tvalid` in 1: tapped tvalid.
- `mon_tready` in 1: tapped tready.
- `mon_tlast` in 1: tapped tlast.
- `mon_tkeep` in KEEP_W: tapped byte enables.
- `enable_in` in 1: from `enable_out`. Gates counting per frame.
- `clear_in` in 1: one-cycle pulse from `clear_counters_out`.
- `pkt_count_out` out 64: completed counted packets.
- `byte_count_out` out 64: sum of counted packet lengths in bytes.
- `irq_req_out` out 1: one-cycle IRQ request pulse.

## Operation
- Beat accepted = `mon_tvalid & mon_tready`. The block never drives the stream.
- Beat bytes = popcount(`mon_tkeep`). Keep bits are not required to be contiguous; every set bit counts.
- Frame FSM:
  - S_IDLE: an accepted beat is the start of frame (SOF).
    - If `enable_in`=1 and `tlast`=1: commit the frame, stay in S_IDLE.
    - If `enable_in`=1 and `tlast`=0: load `frame_acc` with the beat bytes, go to S_FRAME.
    - If `enable_in`=0: go to S_SKIP when `tlast`=0, otherwise stay in S_IDLE.
  - S_FRAME: on each accepted beat, `frame_acc += bytes`. On `tlast`, commit `frame_acc` plus the beat bytes and return to S_IDLE.
  - S_SKIP: ignore beats. On `tlast`, return to S_IDLE.
- `enable_in` is sampled only at SOF. Deasserting it mid-frame still counts that frame.
- Commit: `pkt_count += 1`, `byte_count += frame length`. Both wrap modulo 2^64.
- `frame_acc` is 32 bits and saturates at 0xFFFFFFFF.
- `clear_in`:
  - Zeroes both counters, `pend_cnt` and the timer.
  - Has priority over a same-cycle commit; that frame is lost from the stats and generates no IRQ credit.
  - Does not alter FSM state or `frame_acc`. A frame in progress is counted at its `tlast` after the clear.
- Coalescing:
  - Each commit increments `pend_cnt`.
  - When `pend_cnt` would reach `IRQ_PKT_THRESH` (≠0), pulse `irq_req_out` and set `pend_cnt` to 0.
- Reset mid-frame returns to S_IDLE. A following mid-frame beat is then treated as SOF.

## Timing
- Reset values: `pkt_count_out`=0, `byte_count_out`=0, `irq_req_out`=0, FSM=S_IDLE, `frame_acc`=0, `pend_cnt`=0, timer=0.
- Counter latency: outputs update on the clock edge that samples the `tlast` beat. The new values are visible the next cycle.
- `irq_req_out` is asserted the same cycle the counter update becomes visible. It is high for exactly 1 cycle.
- Back-to-back single-beat frames are supported: one commit per cycle, no bubbles required.
- `clear_in` takes effect on the same edge; outputs read 0 the next cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `ENCAP_STATS_IRQ_TIMEOUT_EN` defined:
  - A 32-bit timer counts every cycle while `pend_cnt`≠0 and resets to 0 on each commit.
  - When the timer reaches `IRQ_TIMEOUT`, pulse `irq_req_out`, then clear `pend_cnt` and the timer.
  - If a threshold IRQ and a timeout IRQ occur in the same cycle, the block emits a single pulse.
- `ENCAP_STATS_IRQ_TIMEOUT_EN` undefined:
  - No timer logic is built and `IRQ_TIMEOUT` is ignored.
  - Pending packets below the threshold never raise an IRQ.

## Test plan
- Reset, then 3 frames of 2 beats each with keep FF/0F (enable=1) → pkt=3, byte=36, no IRQ.
- 16 single-beat frames with keep FF on consecutive cycles → pkt=16, byte=128, exactly one `irq_req_out` pulse, in the cycle after the 16th beat.
- enable=0 at the SOF of a 3-beat frame, enable raised mid-frame, then a 1-beat frame → the first frame is skipped; pkt=1.
- `clear_in` coincident with the `tlast` of a 40-byte frame while pkt=5 → pkt=0 and byte=0 next cycle; the following 8-byte frame gives pkt=1, byte=8.
- With the macro, `IRQ_TIMEOUT`=10, 1 frame and then idle → one IRQ pulse 10 cycles after the commit, and no repeat. Without the macro → no IRQ.
- Keep pattern 0x81 on a single-beat frame, and reset asserted mid-frame → bytes +2; after reset all outputs are 0 and the next beat is treated as SOF.

Source files
------------

// File: rtl/encap_stats_counter.sv
// Passive AXI-Stream egress monitor: 64-bit packet/byte totals with coalesced IRQ.
// Define ENCAP_STATS_IRQ_TIMEOUT_EN to add the idle-timeout IRQ trigger.
module encap_stats_counter #(
  parameter int DATA_WIDTH     = 64,
  parameter int IRQ_PKT_THRESH = 16,
  parameter int IRQ_TIMEOUT    = 1024,
  localparam int KEEP_W        = DATA_WIDTH / 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic              mon_tlast,
  input  logic [KEEP_W-1:0] mon_tkeep,
  input  logic              enable_in,
  input  logic              clear_in,
  output logic [63:0]       pkt_count_out,
  output logic [63:0]       byte_count_out,
  output logic              irq_req_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_SKIP  = 2'd2
  } state_t;

  localparam logic [31:0] THRESH_C = 32'(IRQ_PKT_THRESH);

  state_t      state_q, state_d;
  logic [31:0] frame_acc_q, frame_acc_d;
  logic [63:0] pkt_q, pkt_d;
  logic [63:0] byte_q, byte_d;
  logic [31:0] pend_q, pend_d;
  logic        irq_q, irq_d;

  logic        beat_acc;
  logic [31:0] beat_bytes;
  logic [32:0] acc_sum;
  logic [31:0] acc_sat;
  logic        commit;
  logic [31:0] commit_len;
  logic [31:0] pend_inc;

  assign beat_acc = mon_tvalid & mon_tready;

  // Keep bits may be sparse, so count every set bit.
  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      beat_bytes = beat_bytes + {31'd0, mon_tkeep[i]};
    end
  end

  assign acc_sum = {1'b0, frame_acc_q} + {1'b0, beat_bytes};
  assign acc_sat = acc_sum[32] ? 32'hFFFF_FFFF : acc_sum[31:0];

  always_comb begin
    state_d     = state_q;
    frame_acc_d = frame_acc_q;
    commit      = 1'b0;
    commit_len  = '0;
    case (state_q)
      S_IDLE: begin
        if (beat_acc) begin
          if (enable_in) begin
            if (mon_tlast) begin
              commit     = 1'b1;
              commit_len = beat_bytes;
            end else begin
              frame_acc_d = beat_bytes;
              state_d     = S_FRAME;
            end
          end else if (!mon_tlast) begin
            state_d = S_SKIP;
          end
        end
      end
      S_FRAME: begin
        if (beat_acc) begin
          if (mon_tlast) begin
            commit     = 1'b1;
            commit_len = acc_sat;
            state_d    = S_IDLE;
          end else begin
            frame_acc_d = acc_sat;
          end
        end
      end
      S_SKIP: begin
        if (beat_acc && mon_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pend_inc = pend_q + 32'd1;

`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_C = 32'(IRQ_TIMEOUT);
  logic [31:0] timer_q, timer_d;
  logic [31:0] timer_inc;
  assign timer_inc = timer_q + 32'd1;
`endif

  // Clear wins over a same-cycle commit: that frame is dropped entirely.
  always_comb begin
    pkt_d  = pkt_q;
    byte_d = byte_q;
    pend_d = pend_q;
    irq_d  = 1'b0;
`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
    timer_d = timer_q;
`endif
    if (clear_in) begin
      pkt_d  = '0;
      byte_d = '0;
      pend_d = '0;
`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
      timer_d = '0;
`endif
    end else if (commit) begin
      pkt_d  = pkt_q + 64'd1;
      byte_d = byte_q + {32'd0, commit_len};
      if ((THRESH_C != 32'd0) && (pend_inc == THRESH_C)) begin
        irq_d  = 1'b1;
        pend_d = '0;
      end else begin
        pend_d = pend_inc;
      end
`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
      timer_d = '0;
`endif
    end
`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
    else if (pend_q != 32'd0) begin
      if (timer_inc == TIMEOUT_C) begin
        irq_d   = 1'b1;
        pend_d  = '0;
        timer_d = '0;
      end else begin
        timer_d = timer_inc;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      frame_acc_q <= '0;
      pkt_q       <= '0;
      byte_q      <= '0;
      pend_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_acc_q <= frame_acc_d;
      pkt_q       <= pkt_d;
      byte_q      <= byte_d;
      pend_q      <= pend_d;
      irq_q       <= irq_d;
    end
  end

`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign pkt_count_out  = pkt_q;
  assign byte_count_out = byte_q;
  assign irq_req_out    = irq_q;

endmodule

// File: tb/tb_encap_stats_counter.sv
// Directed bench for encap_stats_counter with hand-computed expectations.
module tb_encap_stats_counter;

  localparam int DW     = 64;
  localparam int KW     = DW / 8;
  localparam int THRESH = 16;
  localparam int TMO    = 10;

  logic          clk;
  logic          rstn;
  logic          mon_tvalid;
  logic          mon_tready;
  logic          mon_tlast;
  logic [KW-1:0] mon_tkeep;
  logic          enable_in;
  logic          clear_in;
  logic [63:0]   pkt_count_out;
  logic [63:0]   byte_count_out;
  logic          irq_req_out;

  int n_cmp;
  int n_bad;

  encap_stats_counter #(
    .DATA_WIDTH    (DW),
    .IRQ_PKT_THRESH(THRESH),
    .IRQ_TIMEOUT   (TMO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .mon_tvalid    (mon_tvalid),
    .mon_tready    (mon_tready),
    .mon_tlast     (mon_tlast),
    .mon_tkeep     (mon_tkeep),
    .enable_in     (enable_in),
    .clear_in      (clear_in),
    .pkt_count_out (pkt_count_out),
    .byte_count_out(byte_count_out),
    .irq_req_out   (irq_req_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge.
  task automatic step(input logic v, input logic r, input logic l, input logic [KW-1:0] k,
                      input logic en, input logic clr);
    mon_tvalid = v;
    mon_tready = r;
    mon_tlast  = l;
    mon_tkeep  = k;
    enable_in  = en;
    clear_in   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic beat(input logic l, input logic [KW-1:0] k);
    step(1'b1, 1'b1, l, k, 1'b1, 1'b0);
  endtask

  initial begin
    int irqs;
    logic timeout_en;
    n_cmp = 0;
    n_bad = 0;
`ifdef ENCAP_STATS_IRQ_TIMEOUT_EN
    timeout_en = 1'b1;
`else
    timeout_en = 1'b0;
`endif
    rstn = 1'b0;
    idle();
    idle();
    rstn = 1'b1;
    idle();
    check("rst_pkt", pkt_count_out, 64'd0);
    check("rst_byte", byte_count_out, 64'd0);
    check("rst_irq", {63'd0, irq_req_out}, 64'd0);

    // Three 2-beat frames, FF then 0F: 12 bytes each.
    irqs = 0;
    for (int f = 0; f < 3; f++) begin
      beat(1'b0, 8'hFF);
      irqs += int'(irq_req_out);
      beat(1'b1, 8'h0F);
      irqs += int'(irq_req_out);
    end
    check("f3_pkt", pkt_count_out, 64'd3);
    check("f3_byte", byte_count_out, 64'd36);
    check("f3_irqs", 64'(irqs), 64'd0);

    // Beat with tready low is not accepted.
    step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    check("noready_pkt", pkt_count_out, 64'd3);

    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check("clr_pkt", pkt_count_out, 64'd0);
    check("clr_byte", byte_count_out, 64'd0);

    // 16 back-to-back single-beat frames: IRQ only after the 16th.
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 8'hFF);
      check($sformatf("thr_irq_%0d", i), {63'd0, irq_req_out}, (i == 15) ? 64'd1 : 64'd0);
    end
    check("thr_pkt", pkt_count_out, 64'd16);
    check("thr_byte", byte_count_out, 64'd128);
    idle();
    check("thr_irq_off", {63'd0, irq_req_out}, 64'd0);

    // Skipped frame: enable low at SOF, raised mid-frame.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
    check("skip_pkt0", pkt_count_out, 64'd0);
    beat(1'b1, 8'h0F);
    check("skip_pkt", pkt_count_out, 64'd1);
    check("skip_byte", byte_count_out, 64'd4);

    // Bring pkt to 5, then a 40-byte frame whose tlast coincides with clear.
    for (int i = 0; i < 4; i++) beat(1'b1, 8'hFF);
    check("pre_clr_pkt", pkt_count_out, 64'd5);
    check("pre_clr_byte", byte_count_out, 64'd36);
    for (int i = 0; i < 4; i++) beat(1'b0, 8'hFF);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    check("clrc_pkt", pkt_count_out, 64'd0);
    check("clrc_byte", byte_count_out, 64'd0);
    check("clrc_irq", {63'd0, irq_req_out}, 64'd0);
    beat(1'b1, 8'hFF);
    check("post_clr_pkt", pkt_count_out, 64'd1);
    check("post_clr_byte", byte_count_out, 64'd8);

    // One pending packet then idle: timeout IRQ on the 10th idle cycle if built.
    irqs = 0;
    for (int i = 1; i <= 20; i++) begin
      idle();
      irqs += int'(irq_req_out);
      check($sformatf("tmo_irq_%0d", i), {63'd0, irq_req_out},
            (timeout_en && i == TMO) ? 64'd1 : 64'd0);
    end
    check("tmo_irqs", 64'(irqs), timeout_en ? 64'd1 : 64'd0);

    // Sparse keep 0x81 counts 2 bytes.
    beat(1'b1, 8'h81);
    check("k81_pkt", pkt_count_out, 64'd2);
    check("k81_byte", byte_count_out, 64'd10);

    // Enable dropped mid-frame still counts the frame; keep 5A = 4 bytes.
    beat(1'b0, 8'h5A);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    check("endrop_pkt", pkt_count_out, 64'd3);
    check("endrop_byte", byte_count_out, 64'd22);

    // Reset mid-frame; the next beat is a SOF.
    beat(1'b0, 8'hFF);
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    check("mrst_pkt", pkt_count_out, 64'd0);
    check("mrst_byte", byte_count_out, 64'd0);
    check("mrst_irq", {63'd0, irq_req_out}, 64'd0);
    beat(1'b1, 8'h0F);
    check("sof_pkt", pkt_count_out, 64'd1);
    check("sof_byte", byte_count_out, 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
